inv_mix_columns_iter: RTL and testbench



---
 rtl/inv_mix_columns_iter.sv | 70 +++++++
 tb/tb_inv_mix_columns_iter.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/inv_mix_columns_iter.sv
// inv_mix_columns_iter: AES InvMixColumns over a 128-bit state, one 32-bit column per clock.
module inv_mix_columns_iter (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state, state_nxt;
    logic [1:0] col;
    logic byp;
    logic [3:0][31:0] st;
    logic [3:0][7:0] cur;
    logic [31:0] mixed;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    // k is one of 09/0b/0d/0e: x8 always present, low bits pick x4/x2/x
    function automatic logic [7:0] gm(input logic [7:0] s, input logic [3:0] k);
        logic [7:0] x2, x4, x8;
        x2 = xtime(s);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ (k[2] ? x4 : 8'h00) ^ (k[1] ? x2 : 8'h00) ^ (k[0] ? s : 8'h00);
    endfunction

    // column 0 lives in the top word, so the packed index is 3-col
    assign cur = st[~col];
    assign mixed = {gm(cur[3], 4'he) ^ gm(cur[2], 4'hb) ^ gm(cur[1], 4'hd) ^ gm(cur[0], 4'h9),
                    gm(cur[3], 4'h9) ^ gm(cur[2], 4'he) ^ gm(cur[1], 4'hb) ^ gm(cur[0], 4'hd),
                    gm(cur[3], 4'hd) ^ gm(cur[2], 4'h9) ^ gm(cur[1], 4'he) ^ gm(cur[0], 4'hb),
                    gm(cur[3], 4'hb) ^ gm(cur[2], 4'hd) ^ gm(cur[1], 4'h9) ^ gm(cur[0], 4'he)};

    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign out_data  = st;

    always_comb begin
        state_nxt = state;
        state_nxt = state == IDLE ? (in_valid ? BUSY : IDLE) :
                    state == BUSY ? (col == 2'd3 ? DONE : BUSY) :
                                    (out_ready ? IDLE : DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col   <= 2'd0;
            st    <= '0;
            byp   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (in_valid && in_ready) begin
                st  <= in_data;
                byp <= in_bypass;
                col <= 2'd0;
            end else if (state == BUSY) begin
                if (!byp) st[~col] <= mixed;
                col <= col == 2'd3 ? col : col + 2'd1;
            end
        end
    end
endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// tb_inv_mix_columns_iter: scoreboard bench; stimulus pushes expected states, a negedge monitor pops and checks.
module tb_inv_mix_columns_iter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0, in_bypass = 1'b0, out_ready = 1'b1;
    logic in_ready, out_valid;
    logic [127:0] in_data = '0, out_data;

    int tests = 0, fails = 0, cyc = 0, last_acc = -1;
    int acc_q[$];
    logic [127:0] exp_q[$];
    logic seen = 1'b0, chk_space = 1'b0;

    localparam logic [127:0] V1 = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] E1 = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V2 = 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d;
    localparam logic [127:0] E2 = 128'hd4d4d4d5_2d26314c_db135345_f20a225c;
    localparam logic [127:0] V3 = 128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8;
    localparam logic [127:0] E3 = 128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c;

    inv_mix_columns_iter dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_bypass(in_bypass), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got %h want %h", name, got, want);
        end
    endtask

    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [127:0] fwd_mix(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127-32*c -: 32];
            r[127-32*c -: 32] = {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
                                 a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
                                 a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
                                 xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst && in_valid && in_ready) begin
            acc_q.push_back(cyc);
            if (chk_space && last_acc >= 0) chk("accept_spacing", 128'(cyc - last_acc), 128'd6);
            last_acc <= cyc;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && in_ready) chk("ready_valid_overlap", 128'd1, 128'd0);
            if (out_valid && !seen) begin
                seen = 1'b1;
                if (acc_q.size() == 0) chk("unexpected_output", out_data, 128'd0);
                else chk("latency", 128'(cyc - acc_q.pop_front() - 1), 128'd4);
            end
            if (out_valid && out_ready) begin
                seen = 1'b0;
                if (exp_q.size() == 0) chk("extra_output", out_data, 128'd0);
                else chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [127:0] d, input logic b, input logic [127:0] e,
                        input logic keep, input logic push);
        int t = 0;
        while (!in_ready && t < 200) begin step(); t++; end
        if (!in_ready) chk("send_timeout", 128'(in_ready), 128'd1);
        in_data = d;
        in_bypass = b;
        in_valid = 1'b1;
        if (push) exp_q.push_back(e);
        step();
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin step(); t++; end
        if (exp_q.size() != 0) chk("drain_timeout", 128'(exp_q.size()), 128'd0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_out_data", out_data, 128'd0);
        step(); step();
        rst = 1'b0;
        step();
        // directed vectors and bypass
        send(V1, 1'b0, E1, 1'b0, 1'b1); drain();
        send(V2, 1'b0, E2, 1'b0, 1'b1); drain();
        send(V1, 1'b1, V1, 1'b0, 1'b1); drain();
        send(V1, 1'b0, E1, 1'b0, 1'b1); drain();
        // backpressure with ignored in_valid pulses
        out_ready = 1'b0;
        send(V2, 1'b0, E2, 1'b0, 1'b1);
        for (int t = 0; t < 20 && !out_valid; t++) step();
        for (int i = 0; i < 10; i++) begin
            step();
            in_valid = i[0];
            in_data = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("stall_out_data", out_data, E2);
            chk("stall_in_ready", 128'(in_ready), 128'd0);
        end
        step();
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        chk("release_in_ready", 128'(in_ready), 128'd1);
        chk("release_out_valid", 128'(out_valid), 128'd0);
        drain();
        // asynchronous reset mid-operation
        send(V1, 1'b0, E1, 1'b0, 1'b0);
        step(); step();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 128'(out_valid), 128'd0);
        chk("midrst_out_data", out_data, 128'd0);
        chk("midrst_in_ready", 128'(in_ready), 128'd1);
        acc_q.delete();
        exp_q.delete();
        seen = 1'b0;
        step();
        rst = 1'b0;
        step();
        send(V3, 1'b0, E3, 1'b0, 1'b1); drain();
        // back-to-back with in_valid held high
        last_acc = -1;
        chk_space = 1'b1;
        send(V1, 1'b0, E1, 1'b1, 1'b1);
        send(V2, 1'b0, E2, 1'b1, 1'b1);
        send(V3, 1'b0, E3, 1'b0, 1'b1);
        drain();
        chk_space = 1'b0;
        // round trip through the forward mix
        for (int i = 0; i < 1000; i++) begin
            logic [127:0] s;
            s = {$urandom, $urandom, $urandom, $urandom};
            send(fwd_mix(s), 1'b0, s, 1'b0, 1'b1);
        end
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
